// File: rtl/nibble_pack_pkg.sv
// nibble_pack_pkg: shared widths, assembly FSM states and the default FIFO
// entry layout for the nibble packing stage.
package nibble_pack_pkg;

   localparam int NIBBLE_W    = 4;
   localparam int DEF_NIBBLES = 4;

   typedef enum logic {
      EMPTY = 1'b0,
      FILL  = 1'b1
   } asm_state_e;

   // Entry layout for the default 4-nibble word; wider builds declare the
   // same three fields at their own width and hand that type to the FIFO.
   typedef struct packed {
      logic [NIBBLE_W*DEF_NIBBLES-1:0]       data;
      logic [$clog2(DEF_NIBBLES+1)-1:0]      count;
      logic [NIBBLE_W-1:0]                   chk;
   } entry_t;

   // Running XOR checksum update with one more nibble.
   function automatic logic [NIBBLE_W-1:0] chk_next(
      input logic [NIBBLE_W-1:0] acc,
      input logic [NIBBLE_W-1:0] nib
   );
      return acc ^ nib;
   endfunction

endpackage

// File: rtl/nibble_pack_fifo.sv
// nibble_pack_fifo: circular synchronous FIFO of word entries with
// read/write pointers and an occupancy counter. DEPTH must be a power of two
// so the pointers wrap naturally.
module nibble_pack_fifo
   import nibble_pack_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type T_ENTRY = entry_t
)(
   input  logic   clk,
   input  logic   rst,
   input  logic   i_push,
   input  T_ENTRY i_entry,
   input  logic   i_pop,
   output T_ENTRY o_head,
   output logic   o_full,
   output logic   o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH + 1);

   T_ENTRY           r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [OCC_W-1:0] r_occ;

   logic w_push;
   logic w_pop;

   assign o_full  = (r_occ == OCC_W'(DEPTH));
   assign o_empty = (r_occ == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_head  = r_mem[r_rd_ptr];

   // Entry storage: written on push only, contents are don't-care until valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_entry;
      end
   end

   // Pointers and occupancy; simultaneous push and pop keep occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + OCC_W'(1);
            2'b01:   r_occ <= r_occ - OCC_W'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

endmodule

// File: rtl/nibble_pack_stage.sv
// nibble_pack_stage: packs a stream of 4-bit nibbles into words of
// NIBBLES_PER_WORD nibbles (first nibble in the low bits), buffers finished
// words in a small FIFO and presents them on a valid/ready interface.
// Optional feature macro: NIBBLE_PACK_CHECKSUM_EN adds a per-word XOR
// checksum on out_chk; without it out_chk is held at zero.
module nibble_pack_stage
   import nibble_pack_pkg::*;
#(
   parameter int NIBBLES_PER_WORD = 4,
   parameter int FIFO_DEPTH       = 2
)(
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      in_valid,
   output logic                                      in_ready,
   input  logic [NIBBLE_W-1:0]                       in_data,
   input  logic                                      in_last,
   output logic                                      out_valid,
   input  logic                                      out_ready,
   output logic [NIBBLE_W*NIBBLES_PER_WORD-1:0]      out_data,
   output logic [$clog2(NIBBLES_PER_WORD+1)-1:0]     out_count,
   output logic [NIBBLE_W-1:0]                       out_chk
);

   localparam int WORD_W = NIBBLE_W * NIBBLES_PER_WORD;
   localparam int IDX_W  = $clog2(NIBBLES_PER_WORD);
   localparam int CNT_W  = $clog2(NIBBLES_PER_WORD + 1);

   typedef struct packed {
      logic [WORD_W-1:0]   data;
      logic [CNT_W-1:0]    count;
`ifdef NIBBLE_PACK_CHECKSUM_EN
      logic [NIBBLE_W-1:0] chk;
`endif
   } word_t;

   asm_state_e        r_state;
   logic [IDX_W-1:0]  r_idx;
   logic [WORD_W-1:0] r_asm;

   logic              w_accept;
   logic              w_close;
   logic              w_full;
   logic              w_empty;
   logic [WORD_W-1:0] w_asm;
   word_t             w_word;
   word_t             w_head;

`ifdef NIBBLE_PACK_CHECKSUM_EN
   logic [NIBBLE_W-1:0] r_chk;
   logic [NIBBLE_W-1:0] w_chk;
`endif

   // Ready comes only from registered occupancy (and is held low in reset).
   assign in_ready = !rst && !w_full;
   assign w_accept = in_valid && in_ready;
   assign w_close  = in_last || (r_idx == IDX_W'(NIBBLES_PER_WORD - 1));

   // Merge the incoming nibble into the word under construction. In EMPTY the
   // assembly register is treated as zero, so stale nibbles from an earlier
   // or reset-abandoned word never leak into the new one.
   always_comb begin
      w_asm = (r_state == EMPTY) ? '0 : r_asm;
      for (int k = 0; k < NIBBLES_PER_WORD; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_asm[k*NIBBLE_W +: NIBBLE_W] = in_data;
         end
      end
`ifdef NIBBLE_PACK_CHECKSUM_EN
      w_chk = chk_next((r_state == EMPTY) ? '0 : r_chk, in_data);
`endif
   end

   // Completed word presented to the FIFO.
   always_comb begin
      w_word.data  = w_asm;
      w_word.count = CNT_W'(r_idx) + CNT_W'(1);
`ifdef NIBBLE_PACK_CHECKSUM_EN
      w_word.chk   = w_chk;
`endif
   end

   // Assembly FSM: EMPTY at index 0, FILL while a word is partially built.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= EMPTY;
         r_idx   <= '0;
      end else if (w_accept) begin
         if (w_close) begin
            r_state <= EMPTY;
            r_idx   <= '0;
         end else begin
            r_state <= FILL;
            r_idx   <= r_idx + IDX_W'(1);
         end
      end
   end

   // Partial-word datapath registers, kept only while a word stays open.
   always_ff @(posedge clk) begin
      if (w_accept && !w_close) begin
         r_asm <= w_asm;
`ifdef NIBBLE_PACK_CHECKSUM_EN
         r_chk <= w_chk;
`endif
      end
   end

   nibble_pack_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .T_ENTRY (word_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_accept && w_close),
      .i_entry (w_word),
      .i_pop   (out_ready),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Head entry is gated to zero when the FIFO is empty.
   assign out_valid = !w_empty;
   assign out_data  = out_valid ? w_head.data  : '0;
   assign out_count = out_valid ? w_head.count : '0;
`ifdef NIBBLE_PACK_CHECKSUM_EN
   assign out_chk   = out_valid ? w_head.chk   : '0;
`else
   assign out_chk   = 4'h0;
`endif

endmodule
